alu_share: RTL and testbench

Two-requester front end for the shared `alu`: accepts ALU operations from two independent clients (A, B) over valid/ready, arbitrates round-robin into a single registered issue stage, drives the combinational `alu`, and returns each result in a per-client response register held until the client consumes it. It sits between the decode/forward logic of two pipelines, for example two hart contexts, and one ALU instance.

---
 rtl/alu_share.sv | 232 +++++++++++++++++++++++
 tb/tb_alu_share.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share.sv
// alu_share: two-client front end for one shared combinational ALU.
// Client A and client B each present one operation at a time over
// valid/ready. A round-robin arbiter loads a single issue register, the ALU
// evaluates from that register, and the next edge parks the result in the
// owning client's response register until that client takes it.
//
// Handshake rules:
//   request : accepted on a rising edge where x_req_valid & x_req_ready;
//             the client holds valid and payload until then.
//   response: consumed on a rising edge where x_rsp_valid & x_rsp_ready;
//             result/sum/flags stay stable while x_rsp_valid is high.

// Shared RISC-V style integer ALU (combinational).
// Flags {eq, lt, ltu} compare op1 against op2 over the full width and are
// reported only for compare-type operations (sub, slt, sltu); otherwise 0.
module alu #(
  parameter int XLEN = 64
) (
  input  logic            i_sub,
  input  logic            i_ashr,
  input  logic [2:0]      i_funct3,
  input  logic            i_w,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  output logic [XLEN-1:0] o_result,
  output logic [XLEN-1:0] o_sum,
  output logic [2:0]      o_flags
);
  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] w_op2_eff;
  logic [XLEN-1:0] w_shr_src;
  logic [XLEN-1:0] w_raw;
  logic [SHW-1:0]  w_shamt;
  logic            w_eq;
  logic            w_lt;
  logic            w_ltu;
  logic            w_cmp;

  assign w_op2_eff = i_sub ? ~i_op2 : i_op2;
  assign o_sum     = i_op1 + w_op2_eff + {{(XLEN-1){1'b0}}, i_sub};
  assign w_eq      = (i_op1 == i_op2);
  assign w_lt      = ($signed(i_op1) < $signed(i_op2));
  assign w_ltu     = (i_op1 < i_op2);
  assign w_cmp     = i_sub | (i_funct3 == 3'b010) | (i_funct3 == 3'b011);
  assign o_flags   = w_cmp ? {w_eq, w_lt, w_ltu} : 3'b000;

  // W-form shifts use a 5-bit amount and operate on the low word only.
  assign w_shamt   = i_w ? SHW'(i_op2[4:0]) : i_op2[SHW-1:0];
  assign w_shr_src = !i_w   ? i_op1 :
                     i_ashr ? {{(XLEN-32){i_op1[31]}}, i_op1[31:0]} :
                              {{(XLEN-32){1'b0}}, i_op1[31:0]};

  // Select the raw result by funct3 before the W-form sign extension.
  always_comb begin
    w_raw = o_sum;
    case (i_funct3)
      3'b000: w_raw = o_sum;
      3'b001: w_raw = i_op1 << w_shamt;
      3'b010: w_raw = {{(XLEN-1){1'b0}}, w_lt};
      3'b011: w_raw = {{(XLEN-1){1'b0}}, w_ltu};
      3'b100: w_raw = i_op1 ^ i_op2;
      3'b101: begin
        if (i_ashr) w_raw = XLEN'($signed(w_shr_src) >>> w_shamt);
        else        w_raw = w_shr_src >> w_shamt;
      end
      3'b110: w_raw = i_op1 | i_op2;
      3'b111: w_raw = i_op1 & i_op2;
      default: w_raw = o_sum;
    endcase
  end

  assign o_result = i_w ? {{(XLEN-32){w_raw[31]}}, w_raw[31:0]} : w_raw;
endmodule

module alu_share #(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            a_req_valid,
  output logic            a_req_ready,
  input  logic            a_sub,
  input  logic            a_ashr,
  input  logic [2:0]      a_funct3,
  input  logic            a_w,
  input  logic [XLEN-1:0] a_op1,
  input  logic [XLEN-1:0] a_op2,
  output logic            a_rsp_valid,
  input  logic            a_rsp_ready,
  output logic [XLEN-1:0] a_result,
  output logic [XLEN-1:0] a_sum,
  output logic [2:0]      a_flags,
  input  logic            b_req_valid,
  output logic            b_req_ready,
  input  logic            b_sub,
  input  logic            b_ashr,
  input  logic [2:0]      b_funct3,
  input  logic            b_w,
  input  logic [XLEN-1:0] b_op1,
  input  logic [XLEN-1:0] b_op2,
  output logic            b_rsp_valid,
  input  logic            b_rsp_ready,
  output logic [XLEN-1:0] b_result,
  output logic [XLEN-1:0] b_sum,
  output logic [2:0]      b_flags
);
  logic            r_busy_a, r_busy_b;
  logic            r_last_b;          // 1: B was granted most recently
  logic            r_iss_valid;
  logic            r_iss_id;          // 0: A, 1: B
  logic            r_iss_sub, r_iss_ashr, r_iss_w;
  logic [2:0]      r_iss_funct3;
  logic [XLEN-1:0] r_iss_op1, r_iss_op2;
  logic            r_a_rsp_valid, r_b_rsp_valid;
  logic [XLEN-1:0] r_a_result, r_a_sum, r_b_result, r_b_sum;
  logic [2:0]      r_a_flags, r_b_flags;

  logic            w_elig_a, w_elig_b;
  logic            w_grant_a, w_grant_b, w_grant;
  logic            w_a_rsp_hs, w_b_rsp_hs;
  logic [XLEN-1:0] w_alu_result, w_alu_sum;
  logic [2:0]      w_alu_flags;

  assign w_elig_a  = a_req_valid & ~r_busy_a;
  assign w_elig_b  = b_req_valid & ~r_busy_b;
  // On a tie the client not granted last time wins.
  assign w_grant_a = w_elig_a & (~w_elig_b | r_last_b);
  assign w_grant_b = w_elig_b & (~w_elig_a | ~r_last_b);
  assign w_grant   = w_grant_a | w_grant_b;
  assign w_a_rsp_hs = r_a_rsp_valid & a_rsp_ready;
  assign w_b_rsp_hs = r_b_rsp_valid & b_rsp_ready;

  // Ready means "accepted if valid": a losing contender sees ready low.
  assign a_req_ready = reset_n & ~r_busy_a & (w_grant_a | ~w_elig_b);
  assign b_req_ready = reset_n & ~r_busy_b & (w_grant_b | ~w_elig_a);

  // Track outstanding operations per client and the last granted client.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_busy_a <= 1'b0;
      r_busy_b <= 1'b0;
      r_last_b <= 1'b1;
    end else begin
      if (w_grant_a)       r_busy_a <= 1'b1;
      else if (w_a_rsp_hs) r_busy_a <= 1'b0;
      if (w_grant_b)       r_busy_b <= 1'b1;
      else if (w_b_rsp_hs) r_busy_b <= 1'b0;
      if (w_grant)         r_last_b <= w_grant_b;
    end
  end

  // Load the issue register from the granted client.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_iss_valid  <= 1'b0;
      r_iss_id     <= 1'b0;
      r_iss_sub    <= 1'b0;
      r_iss_ashr   <= 1'b0;
      r_iss_w      <= 1'b0;
      r_iss_funct3 <= 3'b000;
      r_iss_op1    <= '0;
      r_iss_op2    <= '0;
    end else begin
      r_iss_valid <= w_grant;
      if (w_grant) begin
        r_iss_id     <= w_grant_b;
        r_iss_sub    <= w_grant_b ? b_sub    : a_sub;
        r_iss_ashr   <= w_grant_b ? b_ashr   : a_ashr;
        r_iss_w      <= w_grant_b ? b_w      : a_w;
        r_iss_funct3 <= w_grant_b ? b_funct3 : a_funct3;
        r_iss_op1    <= w_grant_b ? b_op1    : a_op1;
        r_iss_op2    <= w_grant_b ? b_op2    : a_op2;
      end
    end
  end

  alu #(.XLEN(XLEN)) u_alu (
    .i_sub    (r_iss_sub),
    .i_ashr   (r_iss_ashr),
    .i_funct3 (r_iss_funct3),
    .i_w      (r_iss_w),
    .i_op1    (r_iss_op1),
    .i_op2    (r_iss_op2),
    .o_result (w_alu_result),
    .o_sum    (w_alu_sum),
    .o_flags  (w_alu_flags)
  );

  // Client A response slot: capture from the ALU, hold until consumed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_a_rsp_valid <= 1'b0;
      r_a_result    <= '0;
      r_a_sum       <= '0;
      r_a_flags     <= 3'b000;
    end else if (r_iss_valid && !r_iss_id) begin
      r_a_rsp_valid <= 1'b1;
      r_a_result    <= w_alu_result;
      r_a_sum       <= w_alu_sum;
      r_a_flags     <= w_alu_flags;
    end else if (w_a_rsp_hs) begin
      r_a_rsp_valid <= 1'b0;
    end
  end

  // Client B response slot: capture from the ALU, hold until consumed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_b_rsp_valid <= 1'b0;
      r_b_result    <= '0;
      r_b_sum       <= '0;
      r_b_flags     <= 3'b000;
    end else if (r_iss_valid && r_iss_id) begin
      r_b_rsp_valid <= 1'b1;
      r_b_result    <= w_alu_result;
      r_b_sum       <= w_alu_sum;
      r_b_flags     <= w_alu_flags;
    end else if (w_b_rsp_hs) begin
      r_b_rsp_valid <= 1'b0;
    end
  end

  assign a_rsp_valid = r_a_rsp_valid;
  assign a_result    = r_a_result;
  assign a_sum       = r_a_sum;
  assign a_flags     = r_a_flags;
  assign b_rsp_valid = r_b_rsp_valid;
  assign b_result    = r_b_result;
  assign b_sum       = r_b_sum;
  assign b_flags     = r_b_flags;
endmodule

// File: tb/tb_alu_share.sv
// Testbench for alu_share: directed vector table through client A,
// hand-written arbitration / back-pressure / reset sequences, then a
// randomized two-client run against a transaction-level reference model.
module tb_alu_share;
  localparam int XLEN = 64;

  typedef struct packed {
    logic        sub;
    logic        ashr;
    logic [2:0]  f3;
    logic        w;
    logic [63:0] op1;
    logic [63:0] op2;
  } op_t;

  typedef struct {
    op_t         op;
    logic [63:0] exp_res;
    logic [2:0]  exp_flags;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic            a_req_valid, a_req_ready, a_sub, a_ashr, a_w, a_rsp_valid, a_rsp_ready;
  logic            b_req_valid, b_req_ready, b_sub, b_ashr, b_w, b_rsp_valid, b_rsp_ready;
  logic [2:0]      a_funct3, b_funct3, a_flags, b_flags;
  logic [XLEN-1:0] a_op1, a_op2, b_op1, b_op2, a_result, b_result, a_sum, b_sum;

  alu_share #(.XLEN(XLEN)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_sub(a_sub), .a_ashr(a_ashr),
    .a_funct3(a_funct3), .a_w(a_w), .a_op1(a_op1), .a_op2(a_op2),
    .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready),
    .a_result(a_result), .a_sum(a_sum), .a_flags(a_flags),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_sub(b_sub), .b_ashr(b_ashr),
    .b_funct3(b_funct3), .b_w(b_w), .b_op1(b_op1), .b_op2(b_op2),
    .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready),
    .b_result(b_result), .b_sum(b_sum), .b_flags(b_flags)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [130:0] exp_q_a[$];   // {flags, sum, result}
  logic [130:0] exp_q_b[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_result(input op_t o);
    logic [63:0]    r;
    int             sh;
    longint         s1, s2;
    longint unsigned u1, u2;
    int             s1w, s2w, rw;
    int unsigned    u1w;
    s1 = o.op1; s2 = o.op2; u1 = o.op1; u2 = o.op2;
    s1w = o.op1[31:0]; s2w = o.op2[31:0]; u1w = o.op1[31:0];
    r = 64'd0;
    rw = 0;
    if (o.w) begin
      sh = int'(o.op2[4:0]);
      if (o.f3 == 3'd0)      rw = o.sub ? s1w - s2w : s1w + s2w;
      else if (o.f3 == 3'd1) rw = s1w << sh;
      else if (o.f3 == 3'd5) begin
        if (o.ashr) rw = s1w >>> sh;
        else        rw = int'(u1w >> sh);
      end
      r = longint'(rw);
    end else begin
      sh = int'(o.op2[5:0]);
      case (o.f3)
        3'd0: r = o.sub ? u1 - u2 : u1 + u2;
        3'd1: r = u1 << sh;
        3'd2: r = (s1 < s2) ? 64'd1 : 64'd0;
        3'd3: r = (u1 < u2) ? 64'd1 : 64'd0;
        3'd4: r = u1 ^ u2;
        3'd5: begin
          if (o.ashr) r = s1 >>> sh;
          else        r = u1 >> sh;
        end
        3'd6: r = u1 | u2;
        default: r = u1 & u2;
      endcase
    end
    return r;
  endfunction

  function automatic logic [63:0] ref_sum(input op_t o);
    return o.sub ? o.op1 - o.op2 : o.op1 + o.op2;
  endfunction

  function automatic logic [2:0] ref_flags(input op_t o);
    longint s1, s2;
    s1 = o.op1; s2 = o.op2;
    if (!(o.sub || o.f3 == 3'd2 || o.f3 == 3'd3)) return 3'b000;
    return {o.op1 == o.op2, s1 < s2, o.op1 < o.op2};
  endfunction

  function automatic op_t mk_op(input logic sub, input logic ashr, input logic [2:0] f3,
                                input logic w, input logic [63:0] op1, input logic [63:0] op2);
    op_t o;
    o.sub = sub; o.ashr = ashr; o.f3 = f3; o.w = w; o.op1 = op1; o.op2 = op2;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.f3   = 3'($urandom_range(0, 7));
    o.sub  = 1'($urandom_range(0, 1));
    o.ashr = 1'($urandom_range(0, 1));
    o.w    = (o.f3 == 3'd0 || o.f3 == 3'd1 || o.f3 == 3'd5) ? 1'($urandom_range(0, 1)) : 1'b0;
    o.op1  = {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0) o.op1 = 64'($urandom_range(0, 20));
    o.op2  = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0: o.op2 = o.op1;
      1: o.op2 = 64'($urandom_range(0, 70));
      default: ;
    endcase
    return o;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_a(input logic v, input op_t o);
    a_req_valid = v; a_sub = o.sub; a_ashr = o.ashr; a_funct3 = o.f3;
    a_w = o.w; a_op1 = o.op1; a_op2 = o.op2;
  endtask

  task automatic drive_b(input logic v, input op_t o);
    b_req_valid = v; b_sub = o.sub; b_ashr = o.ashr; b_funct3 = o.f3;
    b_w = o.w; b_op1 = o.op1; b_op2 = o.op2;
  endtask

  task automatic idle();
    drive_a(1'b0, '0);
    drive_b(1'b0, '0);
    a_rsp_ready = 1'b0;
    b_rsp_ready = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_a_req_ready"}, a_req_ready, 0);
    check({tag, "_b_req_ready"}, b_req_ready, 0);
    check({tag, "_a_rsp_valid"}, a_rsp_valid, 0);
    check({tag, "_b_rsp_valid"}, b_rsp_valid, 0);
    check({tag, "_a_result"}, a_result, 0);
    check({tag, "_b_result"}, b_result, 0);
    check({tag, "_a_sum"}, a_sum, 0);
    check({tag, "_b_sum"}, b_sum, 0);
    check({tag, "_a_flags"}, a_flags, 0);
    check({tag, "_b_flags"}, b_flags, 0);
  endtask

  // Ends #1 after a rising edge with reset released; the next edge is edge 1.
  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_zero("rst");
    reset_n = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  vec_t vecs[$];
  vec_t v;
  op_t  rq[2];
  logic rv[2], acc[2], rr[2], el[2], exp_rdy[2], m_busy[2], m_rsp_v[2];
  logic m_last, m_iss_v, m_iss_id, gv, g, got;
  logic [130:0] e;
  logic [63:0] hold_res;
  int cnt_a, cnt_b, alt_bad, prev_g, b_done;

  initial begin
    idle();

    // Directed vector table: {op, expected result, expected flags}.
    vecs.push_back('{mk_op(0, 0, 3'd0, 0, 64'd5, 64'd7), 64'd12, 3'b000});
    vecs.push_back('{mk_op(1, 0, 3'd0, 0, 64'd3, 64'd5), 64'hFFFF_FFFF_FFFF_FFFE, 3'b011});
    vecs.push_back('{mk_op(0, 0, 3'd0, 1, 64'h7FFF_FFFF, 64'd1), 64'hFFFF_FFFF_8000_0000, 3'b000});
    vecs.push_back('{mk_op(1, 0, 3'd0, 0, 64'd9, 64'd9), 64'd0, 3'b100});
    vecs.push_back('{mk_op(1, 0, 3'd0, 1, 64'd0, 64'd1), 64'hFFFF_FFFF_FFFF_FFFF, 3'b011});
    vecs.push_back('{mk_op(0, 0, 3'd2, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1), 64'd1, 3'b010});
    vecs.push_back('{mk_op(0, 0, 3'd3, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1), 64'd0, 3'b010});
    vecs.push_back('{mk_op(0, 0, 3'd1, 0, 64'd1, 64'd63), 64'h8000_0000_0000_0000, 3'b000});
    vecs.push_back('{mk_op(0, 0, 3'd1, 0, 64'd1, 64'd68), 64'd16, 3'b000});
    vecs.push_back('{mk_op(0, 0, 3'd1, 1, 64'd1, 64'd31), 64'hFFFF_FFFF_8000_0000, 3'b000});
    vecs.push_back('{mk_op(0, 0, 3'd5, 0, 64'h8000_0000_0000_0000, 64'd4), 64'h0800_0000_0000_0000, 3'b000});
    vecs.push_back('{mk_op(0, 1, 3'd5, 0, 64'h8000_0000_0000_0000, 64'd4), 64'hF800_0000_0000_0000, 3'b000});
    vecs.push_back('{mk_op(0, 1, 3'd5, 1, 64'h0000_0000_8000_0000, 64'd4), 64'hFFFF_FFFF_F800_0000, 3'b000});
    vecs.push_back('{mk_op(0, 0, 3'd5, 1, 64'h0000_0000_8000_0000, 64'd36), 64'h0000_0000_0800_0000, 3'b000});
    vecs.push_back('{mk_op(0, 0, 3'd4, 0, 64'hF0F0, 64'hFF00), 64'h0FF0, 3'b000});
    vecs.push_back('{mk_op(0, 0, 3'd6, 0, 64'hF0F0, 64'hFF00), 64'hFFF0, 3'b000});
    vecs.push_back('{mk_op(0, 0, 3'd7, 0, 64'hF0F0, 64'hFF00), 64'hF000, 3'b000});

    // ---- add, A only: exact latency ----
    do_reset();
    drive_a(1'b1, mk_op(0, 0, 3'd0, 0, 64'd5, 64'd7));
    #1 check("add_a_req_ready", a_req_ready, 1);
    step();                                   // edge 1: handshake
    a_req_valid = 1'b0;
    check("add_rsp_not_yet", a_rsp_valid, 0);
    step();                                   // edge 2: response captured
    check("add_rsp_valid", a_rsp_valid, 1);
    check("add_result", a_result, 64'd12);
    check("add_flags", a_flags, 3'b000);
    a_rsp_ready = 1'b1;
    step();
    a_rsp_ready = 1'b0;
    check("add_rsp_consumed", a_rsp_valid, 0);

    // ---- vector table through client A ----
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive_a(1'b1, v.op);
      #1 check($sformatf("vec%0d_ready", i), a_req_ready, 1);
      step();
      a_req_valid = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
        if (a_rsp_valid) got = 1'b1;
        else step();
      end
      check($sformatf("vec%0d_rsp_seen", i), got, 1);
      check($sformatf("vec%0d_result", i), a_result, v.exp_res);
      check($sformatf("vec%0d_flags", i), a_flags, v.exp_flags);
      check($sformatf("vec%0d_sum", i), a_sum, ref_sum(v.op));
      a_rsp_ready = 1'b1;
      step();
      a_rsp_ready = 1'b0;
      check($sformatf("vec%0d_consumed", i), a_rsp_valid, 0);
    end

    // ---- tie arbitration right after reset ----
    do_reset();
    drive_a(1'b1, mk_op(1, 0, 3'd0, 0, 64'd3, 64'd5));
    drive_b(1'b1, mk_op(0, 0, 3'd0, 0, 64'd1, 64'd1));
    #1;
    check("tie_a_ready", a_req_ready, 1);
    check("tie_b_ready_loser", b_req_ready, 0);
    step();                                   // edge 1: A
    a_req_valid = 1'b0;
    #1 check("tie_b_ready_e2", b_req_ready, 1);
    step();                                   // edge 2: B
    b_req_valid = 1'b0;
    check("tie_a_rsp_valid", a_rsp_valid, 1);
    check("tie_a_result", a_result, 64'hFFFF_FFFF_FFFF_FFFE);
    check("tie_a_flags", a_flags, 3'b011);
    check("tie_b_rsp_early", b_rsp_valid, 0);
    step();                                   // edge 3
    check("tie_b_rsp_valid", b_rsp_valid, 1);
    check("tie_b_result", b_result, 64'd2);
    check("tie_b_flags", b_flags, 3'b000);

    // ---- fairness: both always requesting, rsp_ready tied high ----
    do_reset();
    drive_a(1'b1, mk_op(0, 0, 3'd0, 0, 64'd10, 64'd1));
    drive_b(1'b1, mk_op(0, 0, 3'd0, 0, 64'd20, 64'd2));
    a_rsp_ready = 1'b1;
    b_rsp_ready = 1'b1;
    cnt_a = 0; cnt_b = 0; alt_bad = 0; prev_g = -1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (a_req_valid && a_req_ready) begin
        cnt_a++;
        if (prev_g == 0) alt_bad++;
        prev_g = 0;
      end
      if (b_req_valid && b_req_ready) begin
        cnt_b++;
        if (prev_g == 1) alt_bad++;
        prev_g = 1;
      end
      @(posedge clock);
      #1;
    end
    check("fair_grants_a", 64'(cnt_a), 64'd4);
    check("fair_grants_b", 64'(cnt_b), 64'd4);
    check("fair_alternation", 64'(alt_bad), 64'd0);

    // ---- back-pressure on A while B keeps going ----
    do_reset();
    drive_a(1'b1, mk_op(0, 0, 3'd0, 0, 64'd10, 64'd20));
    drive_b(1'b1, mk_op(0, 0, 3'd0, 0, 64'd4, 64'd4));
    b_rsp_ready = 1'b1;
    step();                                   // edge 1: A accepted
    drive_a(1'b1, mk_op(0, 0, 3'd0, 0, 64'd1, 64'd1));
    step();                                   // edge 2: A rsp, B accepted
    check("bp_a_rsp_valid", a_rsp_valid, 1);
    check("bp_a_result", a_result, 64'd30);
    hold_res = a_result;
    b_done = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("bp_hold_res_%0d", c), a_result, 64'd30);
      check($sformatf("bp_hold_valid_%0d", c), a_rsp_valid, 1);
      check($sformatf("bp_req_ready_%0d", c), a_req_ready, 0);
      if (b_rsp_valid && b_rsp_ready) begin
        check($sformatf("bp_b_result_%0d", c), b_result, 64'd8);
        b_done++;
      end
      step();
    end
    check("bp_b_completed", 64'(b_done), 64'd2);
    a_rsp_ready = 1'b1;
    step();
    a_rsp_ready = 1'b0;
    check("bp_a_rsp_dropped", a_rsp_valid, 0);

    // ---- reset while A's operation is in the issue stage ----
    do_reset();
    drive_a(1'b1, mk_op(0, 0, 3'd0, 0, 64'd5, 64'd7));
    step();                                   // edge 1: handshake
    a_req_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1 check_zero("midrst");
    repeat (2) @(posedge clock);
    #1;
    check_zero("midrst_hold");
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      check($sformatf("midrst_no_rsp_a_%0d", c), a_rsp_valid, 0);
      check($sformatf("midrst_no_rsp_b_%0d", c), b_rsp_valid, 0);
    end

    // ---- randomized two-client run against the reference model ----
    do_reset();
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0; acc[i] = 1'b0; m_busy[i] = 1'b0; m_rsp_v[i] = 1'b0; rq[i] = '0;
    end
    m_last = 1'b1; m_iss_v = 1'b0; m_iss_id = 1'b0;
    exp_q_a.delete();
    exp_q_b.delete();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!rv[i] || acc[i]) begin
          rv[i] = ($urandom_range(0, 99) < 60);
          rq[i] = rand_op();
        end
        acc[i] = 1'b0;
        rr[i] = ($urandom_range(0, 99) < 70);
      end
      drive_a(rv[0], rq[0]);
      drive_b(rv[1], rq[1]);
      a_rsp_ready = rr[0];
      b_rsp_ready = rr[1];
      #1;
      // arbitration expected from the rules
      for (int i = 0; i < 2; i++) el[i] = rv[i] && !m_busy[i];
      gv = el[0] || el[1];
      if (el[0] && el[1]) g = ~m_last;
      else                g = el[1];
      for (int i = 0; i < 2; i++)
        exp_rdy[i] = !m_busy[i] && ((gv && (g == 1'(i))) || !el[1-i]);
      check("rnd_a_req_ready", a_req_ready, exp_rdy[0]);
      check("rnd_b_req_ready", b_req_ready, exp_rdy[1]);
      check("rnd_a_rsp_valid", a_rsp_valid, m_rsp_v[0]);
      check("rnd_b_rsp_valid", b_rsp_valid, m_rsp_v[1]);
      // compare held responses, retire them on handshake
      if (m_rsp_v[0]) begin
        if (exp_q_a.size() == 0) check("rnd_a_queue", 0, 1);
        else begin
          e = exp_q_a[0];
          check("rnd_a_result", a_result, e[63:0]);
          check("rnd_a_sum", a_sum, e[127:64]);
          check("rnd_a_flags", a_flags, e[130:128]);
          if (rr[0]) begin
            void'(exp_q_a.pop_front());
            m_rsp_v[0] = 1'b0;
            m_busy[0] = 1'b0;
          end
        end
      end
      if (m_rsp_v[1]) begin
        if (exp_q_b.size() == 0) check("rnd_b_queue", 0, 1);
        else begin
          e = exp_q_b[0];
          check("rnd_b_result", b_result, e[63:0]);
          check("rnd_b_sum", b_sum, e[127:64]);
          check("rnd_b_flags", b_flags, e[130:128]);
          if (rr[1]) begin
            void'(exp_q_b.pop_front());
            m_rsp_v[1] = 1'b0;
            m_busy[1] = 1'b0;
          end
        end
      end
      // an op issued last cycle lands in its response slot at this edge
      if (m_iss_v) m_rsp_v[m_iss_id] = 1'b1;
      if (gv) begin
        e = {ref_flags(rq[g]), ref_sum(rq[g]), ref_result(rq[g])};
        if (g) exp_q_b.push_back(e);
        else   exp_q_a.push_back(e);
        m_busy[g] = 1'b1;
        acc[g] = 1'b1;
        m_iss_v = 1'b1;
        m_iss_id = g;
        m_last = g;
      end else begin
        m_iss_v = 1'b0;
      end
      @(posedge clock);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
